// File: rtl/frame_read_ctrl.sv
// frame_read_ctrl: reads complete N-sample frames out of a ping-pong buffer
// and hands them to a downstream window/FFT, then waits for its done pulse.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   enable          allows new frame reads to start
//   paquet_ready    pulse: one ping-pong bank has filled
//   fft_ready       downstream can accept a new frame
//   fft_done        pulse: downstream finished the current frame
//   overrun_clr     clears the sticky overrun/timeout flags
//   valid_window    read strobe, one sample per cycle
//   frame_start     first strobe of a frame
//   frame_last      Nth strobe of a frame
//   busy            controller not idle
//   pending [1:0]   filled banks not yet read (0..2)
//   overrun         sticky: a bank was overwritten before being read
//   timeout         sticky: fft_done did not arrive in time
//   frame_count     completed frame reads, wraps at 2^16
module frame_read_ctrl #(
    parameter int N       = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        paquet_ready,
    input  logic        fft_ready,
    input  logic        fft_done,
    input  logic        overrun_clr,
    output logic        valid_window,
    output logic        frame_start,
    output logic        frame_last,
    output logic        busy,
    output logic [1:0]  pending,
    output logic        overrun,
    output logic        timeout,
    output logic [15:0] frame_count
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [1:0]    pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic          to_q, to_d;
    logic [15:0]   fc_q, fc_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;

    logic          start_rd;
    logic          frame_done;
    logic          to_set;
    logic          ovr_set;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        start_rd   = 1'b0;
        frame_done = 1'b0;
        to_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && fft_ready && (pend_q != 2'd0)) begin
                    start_rd = 1'b1;
                    state_d  = S_READ;
                    cnt_d    = '0;
                end
            end
            // enable/fft_ready are deliberately not looked at here:
            // once started, a frame always runs to completion
            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    frame_done = 1'b1;
                    state_d    = S_WAIT;
                    wcnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (fft_done) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    to_set  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A fill and a drain in the same cycle cancel out; a fill with both
    // banks already pending saturates and flags the lost bank.
    always_comb begin
        pend_d  = pend_q;
        ovr_set = 1'b0;
        if (paquet_ready && !start_rd) begin
            if (pend_q == 2'd2) begin
                ovr_set = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (!paquet_ready && start_rd) begin
            pend_d = pend_q - 2'd1;
        end
    end

    // Set has priority over clear on the sticky flags
    always_comb begin
        ovr_d = ovr_q;
        to_d  = to_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end
        if (to_set) begin
            to_d = 1'b1;
        end else if (overrun_clr) begin
            to_d = 1'b0;
        end
    end

    // Strobes are decoded from next state so they line up with the
    // registered state rather than lagging it by a cycle.
    always_comb begin
        fc_d    = frame_done ? fc_q + 16'd1 : fc_q;
        valid_d = (state_d == S_READ);
        start_d = (state_d == S_READ) && (cnt_d == '0);
        last_d  = (state_d == S_READ) && (cnt_d == CNT_LAST);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pend_q  <= 2'd0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
            fc_q    <= 16'd0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
            fc_q    <= fc_d;
            valid_q <= valid_d;
            start_q <= start_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign valid_window = valid_q;
    assign frame_start  = start_q;
    assign frame_last   = last_q;
    assign busy         = busy_q;
    assign pending      = pend_q;
    assign overrun      = ovr_q;
    assign timeout      = to_q;
    assign frame_count  = fc_q;

endmodule

// File: tb/tb_frame_read_ctrl.sv
// tb_frame_read_ctrl: directed scenarios plus a randomized run checked
// against a frame-level reference model.
module tb_frame_read_ctrl;

    localparam int N  = 8;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        paquet_ready = 1'b0;
    logic        fft_ready = 1'b0;
    logic        fft_done = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        valid_window;
    logic        frame_start;
    logic        frame_last;
    logic        busy;
    logic [1:0]  pending;
    logic        overrun;
    logic        timeout;
    logic [15:0] frame_count;

    int total = 0;
    int bad = 0;

    // Reference model: m_idx = strobe index shown (-1 none),
    // m_wait = cycles spent waiting for done (-1 not waiting)
    int m_pend = 0;
    int m_idx = -1;
    int m_wait = -1;
    int m_fc = 0;
    bit m_ovr = 1'b0;
    bit m_to = 1'b0;

    frame_read_ctrl #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .paquet_ready(paquet_ready),
        .fft_ready(fft_ready),
        .fft_done(fft_done),
        .overrun_clr(overrun_clr),
        .valid_window(valid_window),
        .frame_start(frame_start),
        .frame_last(frame_last),
        .busy(busy),
        .pending(pending),
        .overrun(overrun),
        .timeout(timeout),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int st;
        int np;
        bit tset;
        if (reset) begin
            m_pend = 0; m_idx = -1; m_wait = -1;
            m_fc = 0; m_ovr = 1'b0; m_to = 1'b0;
        end else begin
            st = (m_idx < 0 && m_wait < 0 && enable && fft_ready && m_pend > 0) ? 1 : 0;
            np = m_pend + (paquet_ready ? 1 : 0) - st;
            if (np > 2) begin
                np = 2;
                m_ovr = 1'b1;
            end else if (overrun_clr) begin
                m_ovr = 1'b0;
            end
            m_pend = np;
            tset = 1'b0;
            if (st == 1) begin
                m_idx = 0;
            end else if (m_idx >= 0) begin
                if (m_idx == N - 1) begin
                    m_idx = -1;
                    m_wait = 0;
                    m_fc = (m_fc + 1) % 65536;
                end else begin
                    m_idx++;
                end
            end else if (m_wait >= 0) begin
                if (fft_done) begin
                    m_wait = -1;
                end else if (m_wait == TO - 1) begin
                    m_wait = -1;
                    tset = 1'b1;
                end else begin
                    m_wait++;
                end
            end
            if (tset) m_to = 1'b1;
            else if (overrun_clr) m_to = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; fft_ready = 1'b0; paquet_ready = 1'b0;
        fft_done = 1'b0; overrun_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (valid_window !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid_window); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", frame_start); end
        total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", frame_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL rst_pend: got %0d want 0", pending); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %b want 0", overrun); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_to: got %b want 0", timeout); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_fc: got %0d want 0", frame_count); end
    endtask

    task automatic test_single_frame();
        do_reset();
        enable = 1'b1; fft_ready = 1'b1; paquet_ready = 1'b1;
        step();
        paquet_ready = 1'b0;
        total++; if (pending !== 2'd1) begin bad++; $display("FAIL single_pend1: got %0d want 1", pending); end
        total++; if (valid_window !== 1'b0) begin bad++; $display("FAIL single_novalid: got %b want 0", valid_window); end
        for (int i = 0; i < N; i++) begin
            // fft_done during IDLE/READ must be ignored
            fft_done = (i < N - 1);
            step();
            total++; if (valid_window !== 1'b1) begin bad++; $display("FAIL single_valid%0d: got %b want 1", i, valid_window); end
            total++; if (frame_start !== (i == 0)) begin bad++; $display("FAIL single_start%0d: got %b want %b", i, frame_start, (i == 0)); end
            total++; if (frame_last !== (i == N - 1)) begin bad++; $display("FAIL single_last%0d: got %b want %b", i, frame_last, (i == N - 1)); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy%0d: got %b want 1", i, busy); end
        end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL single_pend0: got %0d want 0", pending); end
        fft_done = 1'b0;
        step();
        total++; if (valid_window !== 1'b0) begin bad++; $display("FAIL single_endvalid: got %b want 0", valid_window); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL single_fc: got %0d want 1", frame_count); end
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_waitbusy: got %b want 1", busy); end
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            paquet_ready = 1'b1;
            step();
            paquet_ready = 1'b0;
            step();
            if (p == 1) begin
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", overrun); end
            end
        end
        total++; if (pending !== 2'd2) begin bad++; $display("FAIL ovr_pend: got %0d want 2", pending); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
        paquet_ready = 1'b1; overrun_clr = 1'b1;
        step();
        paquet_ready = 1'b0; overrun_clr = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_setwins: got %b want 1", overrun); end
        total++; if (pending !== 2'd2) begin bad++; $display("FAIL ovr_sat: got %0d want 2", pending); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1; fft_ready = 1'b1; paquet_ready = 1'b1;
        step();
        // second fill lands on the IDLE->READ edge
        step();
        paquet_ready = 1'b0;
        total++; if (valid_window !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", valid_window); end
        total++; if (pending !== 2'd1) begin bad++; $display("FAIL b2b_pend: got %0d want 1", pending); end
        for (int i = 1; i < N; i++) step();
        total++; if (frame_last !== 1'b1) begin bad++; $display("FAIL b2b_last: got %b want 1", frame_last); end
        for (int i = 0; i < 4; i++) step();
        total++; if (valid_window !== 1'b0) begin bad++; $display("FAIL b2b_waitvalid: got %b want 0", valid_window); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_waitbusy: got %b want 1", busy); end
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        total++; if (busy !== 1'b0 || valid_window !== 1'b0) begin bad++; $display("FAIL b2b_gap: got busy=%b valid=%b want 0 0", busy, valid_window); end
        step();
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL b2b_start2: got %b want 1", frame_start); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL b2b_pend0: got %0d want 0", pending); end
    endtask

    task automatic test_timeout();
        do_reset();
        enable = 1'b1; fft_ready = 1'b1; paquet_ready = 1'b1;
        step();
        paquet_ready = 1'b0;
        for (int i = 0; i < N; i++) step();
        step();
        total++; if (busy !== 1'b1 || valid_window !== 1'b0) begin bad++; $display("FAIL to_enter: got busy=%b valid=%b want 1 0", busy, valid_window); end
        for (int k = 1; k < TO; k++) begin
            step();
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_wait%0d: got %b want 1", k, busy); end
        end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", busy); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", timeout); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL to_fc: got %0d want 1", frame_count); end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clr: got %b want 0", timeout); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        enable = 1'b1; fft_ready = 1'b1; paquet_ready = 1'b1;
        step();
        paquet_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        total++; if (valid_window !== 1'b1) begin bad++; $display("FAIL rmid_4th: got %b want 1", valid_window); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (valid_window !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", valid_window); end
        total++; if (pending !== 2'd0) begin bad++; $display("FAIL rmid_pend: got %0d want 0", pending); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rmid_fc: got %0d want 0", frame_count); end
        for (int i = 0; i < N + 2; i++) step();
        total++; if (frame_count !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_after: got fc=%0d busy=%b want 0 0", frame_count, busy); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1; fft_ready = 1'b1; paquet_ready = 1'b1;
        step();
        step();
        paquet_ready = 1'b0;
        step();
        total++; if (valid_window !== 1'b1) begin bad++; $display("FAIL edrop_2nd: got %b want 1", valid_window); end
        enable = 1'b0; fft_ready = 1'b0;
        for (int i = 2; i < N; i++) begin
            step();
            total++; if (valid_window !== 1'b1 || frame_last !== (i == N - 1)) begin bad++; $display("FAIL edrop_strobe%0d: got valid=%b last=%b want 1 %b", i, valid_window, frame_last, (i == N - 1)); end
        end
        step();
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (valid_window !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL edrop_hold%0d: got valid=%b busy=%b want 0 0", i, valid_window, busy); end
        end
        total++; if (pending !== 2'd1) begin bad++; $display("FAIL edrop_pend: got %0d want 1", pending); end
        enable = 1'b1; fft_ready = 1'b1;
        step();
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL edrop_resume: got %b want 1", frame_start); end
    endtask

    task automatic test_random();
        logic [23:0] got_v;
        logic [23:0] exp_v;
        int bad0;
        bad0 = bad;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            enable = ($urandom_range(0, 3) != 0);
            fft_ready = ($urandom_range(0, 3) != 0);
            paquet_ready = ($urandom_range(0, 7) == 0);
            fft_done = ($urandom_range(0, 19) == 0);
            overrun_clr = ($urandom_range(0, 29) == 0);
            step();
            got_v = {valid_window, frame_start, frame_last, busy,
                     pending, overrun, timeout, frame_count};
            exp_v = {(m_idx >= 0), (m_idx == 0), (m_idx == N - 1),
                     (m_idx >= 0 || m_wait >= 0), 2'(m_pend),
                     m_ovr, m_to, 16'(m_fc)};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL rand_cyc%0d: got %h want %h", c, got_v, exp_v);
            end
            if (bad - bad0 >= 20) break;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid_read();
        test_enable_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_read_ctrl.md
FRAME_READ_CTRL -- requirements
Module: frame_read_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 256: samples per frame, which equals the depth of one ping-pong bank.
REQ-002 The block SHALL have parameter TIMEOUT, default 4096: the maximum number of cycles to wait for fft_done.
REQ-003 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  when high, new frame reads may start.
REQ-006 paquet_ready  input  1  one-cycle pulse from the ping-pong buffer meaning one bank is full.
REQ-007 fft_ready  input  1  downstream window/FFT can accept a new frame.
REQ-008 fft_done  input  1  one-cycle pulse meaning downstream has finished the current frame.
REQ-009 overrun_clr  input  1  clears the sticky overrun and timeout flags.
REQ-010 valid_window  output  1  read strobe to the buffer, one sample per cycle.
REQ-011 frame_start  output  1  high with the first valid_window of a frame.
REQ-012 frame_last  output  1  high with the Nth valid_window of a frame.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 pending  output  2  number of filled banks not yet read, range 0..2.
REQ-015 overrun  output  1  sticky; a bank was overwritten before being read.
REQ-016 timeout  output  1  sticky; fft_done did not arrive within TIMEOUT cycles.
REQ-017 frame_count  output  16  number of completed frame reads, wraps modulo 2^16.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 The state machine SHALL have three states: IDLE, READ and WAIT_DONE.
REQ-020 IDLE SHALL go to READ on the cycle that enable, fft_ready and pending>0 are all high.
REQ-021 pending SHALL decrement on the same cycle as the IDLE->READ transition.
REQ-022 pending SHALL increment on paquet_ready.
REQ-023 When paquet_ready and a decrement occur in the same cycle, pending SHALL stay unchanged.
REQ-024 When paquet_ready arrives with pending==2 and no decrement in that cycle, pending SHALL stay 2 and overrun SHALL be set.
REQ-025 In READ, valid_window SHALL be high for exactly N consecutive cycles, counted by an internal counter 0..N-1.
REQ-026 frame_start SHALL be high when the counter is 0, and frame_last when the counter is N-1.
REQ-027 After the frame_last cycle the block SHALL go to WAIT_DONE with valid_window low.
REQ-028 Deasserting enable, or fft_ready going low, during READ SHALL NOT truncate the frame; only complete frames are read.
REQ-029 frame_count SHALL increment on the cycle after frame_last and wrap from 0xFFFF to 0.
REQ-030 WAIT_DONE SHALL return to IDLE on fft_done.
REQ-031 WAIT_DONE SHALL also return to IDLE when its wait counter reaches TIMEOUT-1 with no fft_done, and SHALL set timeout.
REQ-032 The WAIT_DONE wait counter SHALL clear on entry to WAIT_DONE.
REQ-033 fft_done SHALL be ignored in IDLE and READ.
REQ-034 Latency: paquet_ready at cycle t with pending==0 and state IDLE gives pending=1 at t+1; if enable and fft_ready are high at t+1, the first valid_window SHALL appear at t+2.
REQ-035 Back-to-back frames: when pending>0 on return to IDLE, the next READ SHALL begin on the following cycle if enable and fft_ready are high, giving a minimum of one idle cycle between frames.
REQ-036 overrun_clr SHALL clear overrun and timeout.
REQ-037 If a set event and overrun_clr occur in the same cycle, the set SHALL win.
REQ-038 Overrun SHALL also be flagged when a paquet_ready pulse arrives while READ is draining and pending==2; the drain of the current bank continues unaffected.

Reset
REQ-039 On reset the state SHALL be IDLE, the read and wait counters 0, pending 0, and frame_count 0.
REQ-040 On reset valid_window, frame_start, frame_last, busy, overrun and timeout SHALL all be 0.
REQ-041 Reset asserted mid-READ SHALL force valid_window low on the next cycle and discard the partial frame without incrementing frame_count.

Verification
REQ-042 With N=8, enable=1 and fft_ready=1, a single paquet_ready at cycle 10 -> pending=1 at 11, valid_window high at cycles 12..19, frame_start at 12, frame_last at 19, busy from 12, frame_count=1 at 20.
REQ-043 Three paquet_ready pulses with enable=0 -> pending=2, overrun=1 after the third pulse; overrun_clr -> overrun=0.
REQ-044 paquet_ready on the same cycle as the IDLE->READ transition with pending=1 -> pending stays 1, and the second frame reads after fft_done with one idle cycle between frames.
REQ-045 With TIMEOUT=16 and fft_done never asserted -> IDLE reached 16 cycles after entering WAIT_DONE, timeout=1, frame_count still incremented.
REQ-046 Reset at the 4th valid_window of a frame -> valid_window=0 on the next cycle, pending=0, frame_count=0.
REQ-047 enable dropped at the 2nd valid_window -> all N strobes still issued, and no new READ starts until enable returns.
